// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master: SS framing, divided SCK, MOSI shift-out and MISO capture.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
module spi_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SS_SETUP = 2,
  parameter int unsigned SS_HOLD  = 2,
  parameter int unsigned SS_GAP   = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ss_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int unsigned Max01  = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int unsigned Max23  = (SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP;
  localparam int unsigned MaxCnt = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CntW   = (MaxCnt > 2) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] DivLd   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(SS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(SS_HOLD - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(SS_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StLow, StHigh, StHold, StDone, StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q, rx_q, rx_data_q;
  logic            busy_q, done_q, ss_q, sck_q, mosi_q;

  // tx_q holds the bits not yet presented on MOSI; the presented bit lives in mosi_q.
  logic       load_bit, next_bit;
  logic [7:0] load_sh, next_sh, rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign load_bit = tx_data_i[0];
  assign load_sh  = {1'b0, tx_data_i[7:1]};
  assign next_bit = tx_q[0];
  assign next_sh  = {1'b0, tx_q[7:1]};
  assign rx_next  = {miso_i, rx_q[7:1]};
`else
  assign load_bit = tx_data_i[7];
  assign load_sh  = {tx_data_i[6:0], 1'b0};
  assign next_bit = tx_q[7];
  assign next_sh  = {tx_q[6:0], 1'b0};
  assign rx_next  = {rx_q[6:0], miso_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSetup;
            cnt_q   <= SetupLd;
            bit_q   <= '0;
            tx_q    <= load_sh;
            mosi_q  <= load_bit;
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q <= StLow;
            cnt_q   <= DivLd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StLow: begin
          if (cnt_q == '0) begin
            state_q <= StHigh;
            cnt_q   <= DivLd;
            sck_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHigh: begin
          if (cnt_q == '0) begin
            sck_q <= 1'b0;
            // Sample on the falling edge: the slave updates MISO only after SCK falls.
            rx_q  <= rx_next;
            if (bit_q == 3'd7) begin
              state_q <= StHold;
              cnt_q   <= HoldLd;
            end else begin
              state_q <= StLow;
              cnt_q   <= DivLd;
              bit_q   <= bit_q + 3'd1;
              tx_q    <= next_sh;
              mosi_q  <= next_bit;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q   <= StDone;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (SS_GAP == 0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StGap;
            cnt_q   <= GapLd;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ss_o      = ss_q;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default-timing instance with a slave model, fast instance in loopback.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned DivA  = 2;
  localparam int unsigned SetA  = 2;
  localparam int unsigned HoldA = 2;
  localparam int unsigned GapA  = 3;
  localparam int unsigned LatA  = 1 + SetA + 16 * DivA + HoldA;
  localparam int unsigned LatB  = 1 + 1 + 16 * 1 + 1;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       miso_a = 1'b0, miso_b = 1'b0;
  logic [7:0] tx_a = 8'h00, tx_b = 8'h00;
  logic [7:0] rx_a, rx_b;
  logic       busy_a, done_a, ss_a, sck_a, mosi_a;
  logic       busy_b, done_b, ss_b, sck_b, mosi_b;

  always #5 clk = ~clk;

  spi_master #(
    .CLK_DIV (DivA),
    .SS_SETUP(SetA),
    .SS_HOLD (HoldA),
    .SS_GAP  (GapA)
  ) u_dut_a (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_a),
    .tx_data_i(tx_a),
    .rx_data_o(rx_a),
    .busy_o   (busy_a),
    .done_o   (done_a),
    .ss_o     (ss_a),
    .sck_o    (sck_a),
    .mosi_o   (mosi_a),
    .miso_i   (miso_a)
  );

  spi_master #(
    .CLK_DIV (1),
    .SS_SETUP(1),
    .SS_HOLD (1),
    .SS_GAP  (0)
  ) u_dut_b (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_b),
    .tx_data_i(tx_b),
    .rx_data_o(rx_b),
    .busy_o   (busy_b),
    .done_o   (done_b),
    .ss_o     (ss_b),
    .sck_o    (sck_b),
    .mosi_o   (mosi_b),
    .miso_i   (miso_b)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Slave-side view of the default instance's bus.
  logic [7:0] slave_out = 8'h00;
  int         sent = 0, rises = 0, done_cnt = 0, sck_idle_viol = 0;
  int         ss_fall_cyc = 0, rise1_cyc = 0;
  logic       prev_sck = 1'b0, prev_ss = 1'b1;
  logic       mosi_bits[$];

  // Wire order of the i-th transmitted bit within its byte.
  function automatic int ord(input int i);
    return LsbFirst ? i : 7 - i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!ss_a && prev_ss) begin
      sent = 0;
      rises = 0;
      mosi_bits.delete();
      ss_fall_cyc = cyc;
      miso_a = slave_out[ord(0)];
    end
    if (sck_a && !prev_sck) begin
      rises++;
      mosi_bits.push_back(mosi_a);
      if (rises == 1) rise1_cyc = cyc;
    end
    if (!sck_a && prev_sck) begin
      sent++;
      if (sent < 8) miso_a = slave_out[ord(sent)];
    end
    if (sck_a && ss_a) sck_idle_viol++;
    if (done_a) done_cnt++;
    prev_sck = sck_a;
    prev_ss  = ss_a;
    miso_b   = mosi_b;
  endtask

  task automatic xfer_a(input logic [7:0] tx, input logic [7:0] slv, output int lat);
    int n;
    n = 0;
    while (busy_a && n < 200) begin
      tick();
      n++;
    end
    slave_out = slv;
    tx_a = tx;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tx_a = 8'($urandom);
    chk("accept_ss_low", 32'(ss_a), 32'd0);
    chk("accept_busy", 32'(busy_a), 32'd1);
    lat = 1;
    while (!done_a && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] tx, input logic [7:0] slv,
                             input int lat);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 0; i < mosi_bits.size() && i < 8; i++) got[ord(i)] = mosi_bits[i];
    chk({tag, "_lat"}, 32'(lat), LatA);
    chk({tag, "_rx"}, 32'(rx_a), 32'(slv));
    chk({tag, "_slave_got"}, 32'(got), 32'(tx));
    chk({tag, "_rises"}, 32'(rises), 32'd8);
    chk({tag, "_ss_to_sck"}, 32'(rise1_cyc - ss_fall_cyc), SetA + DivA);
    chk({tag, "_sck_while_ss_hi"}, 32'(sck_idle_viol), 32'd0);
  endtask

  task automatic finish_a(input string tag);
    int n;
    tick();
    chk({tag, "_done_width"}, 32'(done_a), 32'd0);
    chk({tag, "_mosi_idle"}, 32'(mosi_a), 32'd0);
    n = 1;
    while (busy_a && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_busy_drop"}, 32'(n), 1 + GapA);
  endtask

  task automatic xfer_b(input logic [7:0] tx);
    int lat;
    tx_b = tx;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tx_b = ~tx;
    lat = 1;
    while (!done_b && lat < 200) begin
      tick();
      lat++;
    end
    chk("b_lat", 32'(lat), LatB);
    chk("b_rx", 32'(rx_b), 32'(tx));
    tick();
    chk("b_busy_drop", 32'(busy_b), 32'd0);
  endtask

  initial begin
    int         lat, n, ss_hi, base;
    logic [7:0] tx, slv;

    // Reset state
    tick();
    tick();
    chk("rst_ss", 32'(ss_a), 32'd1);
    chk("rst_sck", 32'(sck_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rx", 32'(rx_a), 32'd0);
    chk("rst_b", 32'({ss_b, sck_b, mosi_b, busy_b, done_b}), 32'b10000);
    rst_n = 1'b1;
    tick();

    // Directed frame A5 / B1
    xfer_a(8'hA5, 8'hB1, lat);
    check_frame("a5", 8'hA5, 8'hB1, lat);
    finish_a("a5");

    // Single set bit exercises the bit ordering
    xfer_a(8'h01, 8'h80, lat);
    check_frame("x01", 8'h01, 8'h80, lat);
    finish_a("x01");

    // Random frames
    for (int i = 0; i < 5; i++) begin
      tx  = 8'($urandom);
      slv = 8'($urandom);
      xfer_a(tx, slv, lat);
      check_frame("rnd", tx, slv, lat);
      finish_a("rnd");
    end

    // start held high: back-to-back frames, second accepted in the first idle cycle
    slave_out = 8'h1F;
    tx_a = 8'h3C;
    start_a = 1'b1;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    check_frame("b2b1", 8'h3C, 8'h1F, n);
    slave_out = 8'hEA;
    tx_a = 8'hF0;
    ss_hi = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (ss_a && !done_a) ss_hi++;
    end while (!done_a && n < 200);
    start_a = 1'b0;
    chk("b2b_spacing", 32'(n), 1 + GapA + LatA);
    chk("b2b_ss_gap", 32'(ss_hi >= int'(GapA + 1)), 32'd1);
    check_frame("b2b2", 8'hF0, 8'hEA, n - 1 - int'(GapA));
    finish_a("b2b2");

    // start during HIGH of bit 3 is ignored
    base = done_cnt;
    tx = 8'($urandom);
    slv = 8'($urandom);
    slave_out = slv;
    tx_a = tx;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(rises == 4 && sck_a) && n < 200) begin
      tick();
      n++;
    end
    chk("ign_reach_bit3", 32'(n < 200), 32'd1);
    start_a = 1'b1;
    tx_a = ~tx;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    chk("ign_rx", 32'(rx_a), 32'(slv));
    for (int i = 0; i < 60; i++) tick();
    chk("ign_done_count", 32'(done_cnt - base), 32'd1);
    chk("ign_rises", 32'(rises), 32'd8);
    chk("ign_not_queued", 32'({ss_a, busy_a}), 32'b10);

    // Asynchronous reset during bit 4
    tx = 8'($urandom);
    slave_out = 8'($urandom);
    tx_a = tx;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (rises != 5 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_reach_bit4", 32'(n < 200), 32'd1);
    base = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ss", 32'(ss_a), 32'd1);
    chk("arst_sck", 32'(sck_a), 32'd0);
    chk("arst_mosi", 32'(mosi_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_rx", 32'(rx_a), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("arst_no_done", 32'(done_cnt - base), 32'd0);
    chk("arst_idle", 32'({ss_a, busy_a}), 32'b10);
    slv = 8'($urandom);
    xfer_a(8'h3C, slv, lat);
    check_frame("post_rst", 8'h3C, slv, lat);
    finish_a("post_rst");

    // Fast instance, MISO looped back to MOSI
    xfer_b(8'h5A);
    xfer_b(8'h01);
    for (int i = 0; i < 4; i++) xfer_b(8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, driving `SPI_slave` over SS/SCK/MOSI/MISO. Host logic loads a byte with a one-cycle `start` strobe. The block generates SS framing and SCK from the system clock, shifts the byte out on MOSI while capturing MISO, and pulses `done` with the received byte. It replaces bench-driven SCK/SS stimulus as the on-chip initiator for the slave.

## Interface
- `CLK_DIV`, 2: SCK half-period in `clk` cycles; legal range ≥1.
- `SS_SETUP`, 2: `clk` cycles from SS falling to the first SCK rise phase; ≥1.
- `SS_HOLD`, 2: `clk` cycles from the last SCK fall to SS rising; ≥1.
- `SS_GAP`, 3: minimum `clk` cycles SS stays high after a transfer before the next can start; ≥0.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `tx_data`  in  8  byte to send; sampled on the accepting edge.
- `rx_data`  out  8  last received byte; updated in the `done` cycle, held otherwise.
- `busy`  out  1  high from the accept edge until the end of GAP.
- `done`  out  1  one-cycle pulse at transfer end.
- `SS`  out  1  slave select, active low.
- `SCK`  out  1  serial clock, idles low.
- `MOSI`  out  1  serial data out.
- `MISO`  in  1  serial data in.

## Operation
- States: IDLE → SETUP → LOW → HIGH → (LOW … ) → HOLD → GAP → IDLE.
- IDLE:
  - SS=1, SCK=0, MOSI=0, busy=0.
  - `start`=1 latches `tx_data` into the shift register and clears the bit counter. The next state is SETUP with SS=0 and busy=1.
- SETUP: lasts SS_SETUP cycles. SCK=0; MOSI presents bit 7.
- LOW: lasts CLK_DIV cycles with SCK=0. MOSI holds the current bit, which changes only on entry to LOW.
- HIGH: lasts CLK_DIV cycles with SCK=1.
  - In the last HIGH cycle, MISO is shifted into the receive register LSB, matching the slave updating MISO after SCK falls.
  - After bit 0, go to HOLD; otherwise go to LOW with the next bit.
- HOLD: lasts SS_HOLD cycles with SCK=0, SS=0; MOSI holds bit 0.
- End of HOLD:
  - SS=1 and MOSI=0.
  - `done`=1 for exactly one cycle and `rx_data` is loaded in the same cycle.
  - Then go to GAP.
- GAP: lasts SS_GAP cycles with busy=1. SS_GAP=0 returns to IDLE directly after the done cycle.
- `start` while busy=1 is ignored and not queued. `tx_data` changes after acceptance have no effect.
- Exactly 8 SCK rising edges per transfer. SCK never toggles while SS=1.
- Counters: bit counter is 3 bits; phase counter is wide enough for max(CLK_DIV, SS_SETUP, SS_HOLD, SS_GAP).

## Timing
- Reset (async assert, applies immediately, including mid-transfer):
  - SS=1, SCK=0, MOSI=0.
  - busy=0, done=0, rx_data=8'h00.
  - State returns to IDLE; a partial byte is discarded and `done` is not pulsed.
- Accept edge to SS low: 1 cycle.
- SS low to first SCK rise: SS_SETUP + CLK_DIV cycles.
- Accept edge to `done`: 1 + SS_SETUP + 16·CLK_DIV + SS_HOLD cycles.
- `done` to busy=0: 1 + SS_GAP cycles. The earliest next accept is in the cycle busy=0 is first seen.
- With `start` held high continuously, a new transfer is accepted in the first IDLE cycle.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: bit 0 is sent first and the receive register shifts in from the MSB side, so the first received bit lands in rx_data[0].
  - Undefined (default): MSB first, as described above.
- Timing and framing are identical in both builds.

## Test plan
- Reset pulse low for 1 cycle mid-transfer (during bit 4) → SS=1, SCK=0, MOSI=0, busy=0 immediately. No `done` pulse. The next transfer of 8'h3C completes correctly.
- `tx_data`=8'hA5 with a slave model returning 8'hB1 → MOSI bits 1,0,1,0,0,1,0,1 on successive SCK rises. `done` arrives at cycle 1+2+32+2=37 after accept, with `rx_data`=8'hB1. The slave OUT reads 8'hA5.
- Back-to-back 8'h3C/1F then 8'hF0/EA with `start` held high → two `done` pulses. SS is high for ≥ SS_GAP+1 cycles between transfers. `rx_data`=8'h1F then 8'hEA.
- `start` pulsed during HIGH of bit 3 of a transfer → ignored. Exactly one `done` pulse and 8 SCK rises.
- CLK_DIV=1, SS_SETUP=1, SS_HOLD=1, SS_GAP=0 with loopback MISO=MOSI and 8'h5A → `rx_data`=8'h5A. `done` arrives 19 cycles after accept and busy drops on the next cycle.
- With `SPI_MASTER_LSB_FIRST_EN`, `tx_data`=8'h01 → MOSI=1 only on the first SCK rise. With loopback, `rx_data`=8'h01.
